// File: rtl/sw_accumulator.sv
// Push-button accumulator: adds synchronized switch value on each debounced
// accumulate press, clears on clear press, with wrap or saturate overflow.
module sw_accumulator #(
    parameter int unsigned SW_W       = 8,
    parameter int unsigned ACC_W      = 16,
    parameter int unsigned LED_W      = 8,
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned SATURATE   = 0
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [SW_W-1:0]  SW,
    input  logic             accum_key_n,
    input  logic             clear_key_n,
    output logic [ACC_W-1:0] acc_value,
    output logic [LED_W-1:0] LED,
    output logic             overflow,
    output logic             acc_pulse
);

    localparam int unsigned KEYS    = 2;
    localparam int unsigned KEY_ACC = 0;
    localparam int unsigned KEY_CLR = 1;
    localparam int unsigned CNT_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned SUM_W   = ACC_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic [SW_W-1:0]             sw_s1_q, sw_s2_q;
    logic [KEYS-1:0]             key_s1_q, key_s2_q;
    logic [KEYS-1:0]             deb_q, deb_d;
    logic [KEYS-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [KEYS-1:0]             press_c;
    logic [ACC_W-1:0]            acc_q, acc_d;
    logic                        ovf_q, ovf_d;
    logic                        pulse_q, pulse_d;
    logic [SUM_W-1:0]            sum_c;

    // Debouncers: a press is the cycle in which deb falls 1->0
    always_comb begin
        deb_d   = deb_q;
        cnt_d   = cnt_q;
        press_c = '0;
        for (int i = 0; i < int'(KEYS); i++) begin
            if (key_s2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] < CNT_MAX) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else begin
                deb_d[i]   = key_s2_q[i];
                cnt_d[i]   = '0;
                press_c[i] = deb_q[i];
            end
        end
    end

    assign sum_c = {1'b0, acc_q} + SUM_W'(sw_s2_q);

    // Clear outranks accumulate; overflow is sticky until clear
    always_comb begin
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        pulse_d = 1'b0;
        if (press_c[KEY_CLR]) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (press_c[KEY_ACC]) begin
            pulse_d = 1'b1;
            acc_d   = sum_c[ACC_W-1:0];
            if (sum_c[ACC_W]) begin
                ovf_d = 1'b1;
                if (SATURATE != 0) begin
                    acc_d = '1;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            key_s1_q <= '1;
            key_s2_q <= '1;
            deb_q    <= '1;
            cnt_q    <= '0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            sw_s1_q  <= SW;
            sw_s2_q  <= sw_s1_q;
            key_s1_q <= {clear_key_n, accum_key_n};
            key_s2_q <= key_s1_q;
            deb_q    <= deb_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
            pulse_q  <= pulse_d;
        end
    end

    assign acc_value = acc_q;
    assign LED       = acc_q[LED_W-1:0];
    assign overflow  = ovf_q;
    assign acc_pulse = pulse_q;

endmodule

// File: tb/tb_sw_accumulator.sv
// Scoreboard bench for sw_accumulator: three instances (16-bit wrap, 8-bit wrap,
// 8-bit saturate); expectations are queued per edge and checked by a monitor.
module tb_sw_accumulator;

    typedef struct {
        int          dut;
        int          cyc;
        logic [15:0] acc;
        logic        ovf;
        logic        pulse;
    } exp_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    exp_t        sbq[$];

    logic        rst_n [3];
    logic [7:0]  sw    [3];
    logic        ak    [3];
    logic        ck    [3];

    logic [15:0] acc0;
    logic [7:0]  acc1, acc2;
    logic [7:0]  led0, led1, led2;
    logic        ovf0, ovf1, ovf2;
    logic        pls0, pls1, pls2;

    logic [15:0] m_acc [3];
    logic [7:0]  m_led [3];
    logic        m_ovf [3];
    logic        m_pls [3];
    bit          seen  [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sw_accumulator #(.SW_W(8), .ACC_W(16), .LED_W(8), .DEB_CYCLES(4), .SATURATE(0)) u_dut0 (
        .Clk(clk), .Reset_n(rst_n[0]), .SW(sw[0]), .accum_key_n(ak[0]), .clear_key_n(ck[0]),
        .acc_value(acc0), .LED(led0), .overflow(ovf0), .acc_pulse(pls0));
    sw_accumulator #(.SW_W(8), .ACC_W(8), .LED_W(8), .DEB_CYCLES(4), .SATURATE(0)) u_dut1 (
        .Clk(clk), .Reset_n(rst_n[1]), .SW(sw[1]), .accum_key_n(ak[1]), .clear_key_n(ck[1]),
        .acc_value(acc1), .LED(led1), .overflow(ovf1), .acc_pulse(pls1));
    sw_accumulator #(.SW_W(8), .ACC_W(8), .LED_W(8), .DEB_CYCLES(4), .SATURATE(1)) u_dut2 (
        .Clk(clk), .Reset_n(rst_n[2]), .SW(sw[2]), .accum_key_n(ak[2]), .clear_key_n(ck[2]),
        .acc_value(acc2), .LED(led2), .overflow(ovf2), .acc_pulse(pls2));

    assign m_acc[0] = acc0;
    assign m_acc[1] = {8'h00, acc1};
    assign m_acc[2] = {8'h00, acc2};
    assign m_led[0] = led0;
    assign m_led[1] = led1;
    assign m_led[2] = led2;
    assign m_ovf[0] = ovf0;
    assign m_ovf[1] = ovf1;
    assign m_ovf[2] = ovf2;
    assign m_pls[0] = pls0;
    assign m_pls[1] = pls1;
    assign m_pls[2] = pls2;

    task automatic chk(string name, int d, logic [15:0] act, logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d edge %0d: got %h expected %h", name, d, cyc, act, exp);
        end
    endtask

    // Monitor: compare queued expectations due at this edge; otherwise no strobe allowed
    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int d = 0; d < 3; d++) seen[d] = 1'b0;
            while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                exp_t e;
                e = sbq.pop_front();
                if (e.cyc < cyc) begin
                    chk("stale_expectation", e.dut, 16'(cyc), 16'(e.cyc));
                end else begin
                    chk("acc_value", e.dut, m_acc[e.dut], e.acc);
                    chk("led", e.dut, 16'(m_led[e.dut]), 16'(e.acc[7:0]));
                    chk("overflow", e.dut, 16'(m_ovf[e.dut]), 16'(e.ovf));
                    chk("acc_pulse", e.dut, 16'(m_pls[e.dut]), 16'(e.pulse));
                    seen[e.dut] = 1'b1;
                end
            end
            for (int d = 0; d < 3; d++)
                if (!seen[d]) chk("idle_pulse", d, 16'(m_pls[d]), 16'h0);
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(int d, int c, logic [15:0] a, logic o, logic p);
        exp_t e;
        e.dut = d; e.cyc = c; e.acc = a; e.ovf = o; e.pulse = p;
        sbq.push_back(e);
    endtask

    // Accumulate press: key falls after edge e, takes effect on edge e+6
    task automatic do_acc(int d, logic [7:0] v, logic [15:0] pre, logic opre,
                          logic [15:0] post, logic opost);
        int e;
        sw[d] = v;
        tick(3);
        e = cyc;
        ak[d] = 1'b0;
        push(d, e + 5, pre, opre, 1'b0);
        push(d, e + 6, post, opost, 1'b1);
        push(d, e + 7, post, opost, 1'b0);
        tick(10);
        ak[d] = 1'b1;
        tick(8);
        push(d, cyc + 1, post, opost, 1'b0);
        tick(1);
    endtask

    task automatic do_clr(int d, bit both, logic [15:0] pre, logic opre);
        int e;
        tick(1);
        e = cyc;
        ck[d] = 1'b0;
        if (both) ak[d] = 1'b0;
        push(d, e + 5, pre, opre, 1'b0);
        push(d, e + 6, 16'h0, 1'b0, 1'b0);
        push(d, e + 7, 16'h0, 1'b0, 1'b0);
        tick(10);
        ck[d] = 1'b1;
        ak[d] = 1'b1;
        tick(8);
    endtask

    initial begin
        int e;
        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b0; sw[d] = 8'h00; ak[d] = 1'b1; ck[d] = 1'b1;
        end
        for (int c = 1; c <= 2; c++)
            for (int d = 0; d < 3; d++) push(d, c, 16'h0, 1'b0, 1'b0);
        tick(2);
        for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
        tick(3);

        // Single press held 50 cycles: one accumulation, no repeat
        sw[0] = 8'h25;
        tick(3);
        e = cyc;
        ak[0] = 1'b0;
        push(0, e + 5, 16'h0000, 1'b0, 1'b0);
        push(0, e + 6, 16'h0025, 1'b0, 1'b1);
        push(0, e + 7, 16'h0025, 1'b0, 1'b0);
        push(0, e + 50, 16'h0025, 1'b0, 1'b0);
        tick(50);
        ak[0] = 1'b1;
        tick(10);

        // Glitches shorter than the debounce window are ignored
        ak[0] = 1'b0; tick(3);
        ak[0] = 1'b1; tick(2);
        ak[0] = 1'b0; tick(3);
        ak[0] = 1'b1; tick(10);
        push(0, cyc + 1, 16'h0025, 1'b0, 1'b0);
        tick(1);

        do_acc(0, 8'h00, 16'h0025, 1'b0, 16'h0025, 1'b0);
        do_acc(0, 8'hFF, 16'h0025, 1'b0, 16'h0124, 1'b0);
        do_clr(0, 1'b0, 16'h0124, 1'b0);
        do_acc(0, 8'h42, 16'h0000, 1'b0, 16'h0042, 1'b0);
        do_clr(0, 1'b1, 16'h0042, 1'b0);
        do_acc(0, 8'h10, 16'h0000, 1'b0, 16'h0010, 1'b0);

        // Reset pulse mid-debounce with key held: full latency restarts
        tick(1);
        e = cyc;
        ak[0] = 1'b0;
        push(0, e + 2, 16'h0010, 1'b0, 1'b0);
        push(0, e + 3, 16'h0000, 1'b0, 1'b0);
        push(0, e + 8, 16'h0000, 1'b0, 1'b0);
        push(0, e + 9, 16'h0010, 1'b0, 1'b1);
        push(0, e + 10, 16'h0010, 1'b0, 1'b0);
        tick(2);
        rst_n[0] = 1'b0;
        tick(1);
        rst_n[0] = 1'b1;
        tick(12);
        ak[0] = 1'b1;
        tick(8);

        // 8-bit wrap
        do_acc(1, 8'h78, 16'h00, 1'b0, 16'h78, 1'b0);
        do_acc(1, 8'h78, 16'h78, 1'b0, 16'hF0, 1'b0);
        do_acc(1, 8'h20, 16'hF0, 1'b0, 16'h10, 1'b1);
        do_acc(1, 8'h01, 16'h10, 1'b1, 16'h11, 1'b1);
        do_clr(1, 1'b0, 16'h11, 1'b1);
        do_acc(1, 8'h05, 16'h00, 1'b0, 16'h05, 1'b0);

        // 8-bit saturate
        do_acc(2, 8'h78, 16'h00, 1'b0, 16'h78, 1'b0);
        do_acc(2, 8'h78, 16'h78, 1'b0, 16'hF0, 1'b0);
        do_acc(2, 8'h20, 16'hF0, 1'b0, 16'hFF, 1'b1);
        do_acc(2, 8'h20, 16'hFF, 1'b1, 16'hFF, 1'b1);
        do_acc(2, 8'h00, 16'hFF, 1'b1, 16'hFF, 1'b1);
        do_clr(2, 1'b0, 16'hFF, 1'b1);

        tick(5);
        chk("queue_drained", 0, 16'(sbq.size()), 16'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, edge %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
